// File: rtl/exp_pkg.sv
// Shared types for the exception request generator: FSM states, source ids,
// grant priority order and small source-id helpers.
package exp_pkg;

   localparam int NUM_EXP_SRC = 3;

   typedef logic [1:0] src_id_t;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_REQ       = 2'd1,
      ST_WAIT_DONE = 2'd2
   } exp_state_e;

   // Highest priority first.
   localparam src_id_t PRIO_ORDER [NUM_EXP_SRC] = '{2'd2, 2'd1, 2'd0};

   function automatic src_id_t pick_grant(input logic [NUM_EXP_SRC-1:0] req);
      src_id_t id;
      id = PRIO_ORDER[0];
      for (int i = NUM_EXP_SRC - 1; i >= 0; i--) begin
         if (req[PRIO_ORDER[i]]) begin
            id = PRIO_ORDER[i];
         end else begin
            id = id;
         end
      end
      return id;
   endfunction

   function automatic logic [NUM_EXP_SRC-1:0] id_to_onehot(input src_id_t id);
      logic [NUM_EXP_SRC-1:0] one;
      one = {{(NUM_EXP_SRC-1){1'b0}}, 1'b1};
      return one << id;
   endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer; emits a
// one-cycle registered pulse when the debounced level rises.
module debounce_sync #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_async,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             level_d;
   logic             rise_q;
   logic             rise_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count differing samples; a matching sample restarts the count.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_q + CNT_ONE;
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Synchronizer, counter, level and rise pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_async;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/exp_request_gen.sv
// Debounces three exception buttons, latches pending requests and hands them
// one at a time to the CPU. Optional overrun counter: EXP_OVERRUN_CNT_EN.
module exp_request_gen
   import exp_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int CNT_W           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] btn,
   input  logic       expblock,
   input  logic       ack,
   output logic       expsrc0,
   output logic       expsrc1,
   output logic       expsrc2,
   output logic [2:0] pending,
   output logic       busy
`ifdef EXP_OVERRUN_CNT_EN
   ,
   output logic [7:0] overrun_cnt
`endif
);

   logic [NUM_EXP_SRC-1:0] rise_s;
   logic [NUM_EXP_SRC-1:0] clr_s;
   logic [NUM_EXP_SRC-1:0] pending_q;
   logic [NUM_EXP_SRC-1:0] pending_d;
   logic [NUM_EXP_SRC-1:0] expsrc_q;
   logic [NUM_EXP_SRC-1:0] expsrc_d;
   exp_state_e             state_q;
   exp_state_e             state_d;
   src_id_t                grant_q;
   src_id_t                grant_d;
   logic                   busy_q;
   logic                   busy_d;

   for (genvar g = 0; g < NUM_EXP_SRC; g++) begin : g_db
      debounce_sync #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_debounce_sync (
         .clk       (clk),
         .reset     (reset),
         .btn_async (btn[g]),
         .rise      (rise_s[g])
      );
   end

   // Grant FSM next-state and output decode; grant id frozen outside IDLE.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      expsrc_d = expsrc_q;
      busy_d   = busy_q;
      clr_s    = '0;
      case (state_q)
         ST_IDLE: begin
            if ((pending_q != 3'b000) && !expblock) begin
               grant_d  = pick_grant(pending_q);
               expsrc_d = id_to_onehot(grant_d);
               busy_d   = 1'b1;
               state_d  = ST_REQ;
            end else begin
               expsrc_d = '0;
               busy_d   = 1'b0;
            end
         end
         ST_REQ: begin
            if (ack) begin
               clr_s    = id_to_onehot(grant_q);
               expsrc_d = '0;
               state_d  = ST_WAIT_DONE;
            end else begin
               expsrc_d = id_to_onehot(grant_q);
            end
         end
         ST_WAIT_DONE: begin
            if (!ack) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_WAIT_DONE;
            end
         end
         default: begin
            expsrc_d = '0;
            busy_d   = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // A new rise beats a same-cycle clear so the fresh edge is not lost.
   always_comb begin
      pending_d = (pending_q & ~clr_s) | rise_s;
   end

   // Grant FSM state and registered CPU-facing outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         grant_q  <= 2'd0;
         expsrc_q <= '0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         expsrc_q <= expsrc_d;
         busy_q   <= busy_d;
      end
   end

   // Pending request latch.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

`ifdef EXP_OVERRUN_CNT_EN
   logic       ovr_ev_s;
   logic [7:0] ovr_q;
   logic [7:0] ovr_d;

   // Any number of simultaneous overruns counts once; saturates at 255.
   always_comb begin
      ovr_ev_s = |(rise_s & pending_q & ~clr_s);
      if (ovr_ev_s && (ovr_q != 8'hFF)) begin
         ovr_d = ovr_q + 8'd1;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // Overrun counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovr_q <= 8'd0;
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign overrun_cnt = ovr_q;
`endif

   assign expsrc0 = expsrc_q[0];
   assign expsrc1 = expsrc_q[1];
   assign expsrc2 = expsrc_q[2];
   assign pending = pending_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_exp_request_gen.sv
// Self-checking bench for exp_request_gen (DEBOUNCE_CYCLES = 4): directed
// scenarios plus randomized stimulus against a sample-window reference model.
module tb_exp_request_gen;

   localparam int DB = 4;

   logic       clk;
   logic       reset;
   logic [2:0] btn;
   logic       expblock;
   logic       ack;
   logic       expsrc0;
   logic       expsrc1;
   logic       expsrc2;
   logic [2:0] pending;
   logic       busy;
`ifdef EXP_OVERRUN_CNT_EN
   logic [7:0] overrun_cnt;
`endif

   int n_cmp;
   int n_mis;
   logic chk_en;

   exp_request_gen #(
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btn         (btn),
      .expblock    (expblock),
      .ack         (ack),
      .expsrc0     (expsrc0),
      .expsrc1     (expsrc1),
      .expsrc2     (expsrc2),
      .pending     (pending),
      .busy        (busy)
`ifdef EXP_OVERRUN_CNT_EN
      ,
      .overrun_cnt (overrun_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic logic [2:0] oh(input int id);
      logic [2:0] one;
      one = 3'b001;
      return one << id;
   endfunction

   // Reference model: debounced level flips when the last DB synchronized
   // samples all disagree with it; requests handled as a priority handshake.
   logic [2:0]    m_s1, m_s2, m_lvl, m_rise, m_pend, m_src;
   logic [DB-1:0] m_win [3];
   int            m_seen [3];
   int            m_state;
   int            m_grant;
   logic          m_busy;
   int            m_ovr;

   always @(posedge clk or posedge reset) begin : ref_model
      logic [2:0]    clr;
      logic [2:0]    lvl_n;
      logic [2:0]    rise_n;
      logic [DB-1:0] w;
      int            sn;
      int            g;
      if (reset) begin
         m_s1 <= '0; m_s2 <= '0; m_lvl <= '0; m_rise <= '0; m_pend <= '0; m_src <= '0;
         for (int n = 0; n < 3; n++) begin
            m_win[n]  <= '0;
            m_seen[n] <= 0;
         end
         m_state <= 0; m_grant <= 0; m_busy <= 1'b0; m_ovr <= 0;
      end else begin
         lvl_n  = m_lvl;
         rise_n = '0;
         for (int n = 0; n < 3; n++) begin
            w  = {m_win[n][DB-2:0], m_s2[n]};
            sn = (m_seen[n] < DB) ? m_seen[n] + 1 : DB;
            if (sn == DB && w == {DB{~m_lvl[n]}}) begin
               lvl_n[n]  = ~m_lvl[n];
               rise_n[n] = ~m_lvl[n];
            end
            m_win[n]  <= w;
            m_seen[n] <= sn;
         end
         m_lvl  <= lvl_n;
         m_rise <= rise_n;
         m_s2   <= m_s1;
         m_s1   <= btn;
         clr = '0;
         case (m_state)
            0: if (m_pend != 3'b000 && !expblock) begin
                  g = m_pend[2] ? 2 : (m_pend[1] ? 1 : 0);
                  m_grant <= g;
                  m_src   <= oh(g);
                  m_state <= 1;
                  m_busy  <= 1'b1;
               end
            1: if (ack) begin
                  clr = oh(m_grant);
                  m_src   <= '0;
                  m_state <= 2;
               end
            default: if (!ack) begin
                  m_state <= 0;
                  m_busy  <= 1'b0;
               end
         endcase
         m_pend <= (m_pend & ~clr) | m_rise;
         if (|(m_rise & m_pend & ~clr) && m_ovr < 255) m_ovr <= m_ovr + 1;
      end
   end

   // Continuous comparison against the model away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check_val("expsrc", 32'({expsrc2, expsrc1, expsrc0}), 32'(m_src));
         check_val("pending", 32'(pending), 32'(m_pend));
         check_val("busy", 32'(busy), 32'(m_busy));
         check_val("onehot", 32'($countones({expsrc2, expsrc1, expsrc0}) <= 1), 32'(1));
`ifdef EXP_OVERRUN_CNT_EN
         check_val("overrun", 32'(overrun_cnt), 32'(m_ovr));
`endif
      end
   end

   task automatic settle(input int n);
      btn = 3'b000; expblock = 1'b0; ack = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_src(input string tag, input logic [2:0] exp_v);
      int t;
      t = 0;
      while ({expsrc2, expsrc1, expsrc0} == 3'b000 && t < 40) begin
         @(negedge clk);
         t++;
      end
      check_val(tag, 32'({expsrc2, expsrc1, expsrc0}), 32'(exp_v));
   endtask

   task automatic serve(input string tag, input int id);
      wait_src(tag, oh(id));
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int hold_b, hold_a;
      n_cmp = 0; n_mis = 0; chk_en = 1'b0;
      btn = 3'b000; expblock = 1'b0; ack = 1'b0; reset = 1'b1;
      #1;
      check_val("rst_src", 32'({expsrc2, expsrc1, expsrc0}), 32'd0);
      check_val("rst_pend", 32'(pending), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk_en = 1'b1;
      settle(4);

      // Clean rise on source 0: exact latency and full handshake.
      btn = 3'b001;
      repeat (6) @(negedge clk);
      check_val("lat_early", 32'(pending), 32'd0);
      @(negedge clk);
      check_val("lat_set", 32'(pending), 32'b001);
      @(negedge clk);
      check_val("src0_up", 32'({expsrc2, expsrc1, expsrc0}), 32'b001);
      ack = 1'b1;
      @(negedge clk);
      check_val("ack_drop", 32'({expsrc2, expsrc1, expsrc0}), 32'd0);
      check_val("ack_clr", 32'(pending), 32'd0);
      check_val("ack_busy", 32'(busy), 32'd1);
      repeat (2) @(negedge clk);
      ack = 1'b0;
      @(negedge clk);
      check_val("idle_busy", 32'(busy), 32'd0);
      settle(12);

      // Bouncing input never accepted.
      for (int i = 0; i < 20; i++) begin
         btn = (i % 2 == 0) ? 3'b001 : 3'b000;
         repeat (2) @(negedge clk);
      end
      check_val("bounce_pend", 32'(pending), 32'd0);
      settle(12);

      // All three at once: served by priority.
      btn = 3'b111;
      serve("prio2", 2);
      serve("prio1", 1);
      serve("prio0", 0);
      settle(12);

      // Mask holds off grant.
      expblock = 1'b1;
      btn = 3'b010;
      repeat (27) @(negedge clk);
      check_val("blk_src", 32'({expsrc2, expsrc1, expsrc0}), 32'd0);
      check_val("blk_pend", 32'(pending), 32'b010);
      expblock = 1'b0;
      @(negedge clk);
      check_val("unblk_src", 32'({expsrc2, expsrc1, expsrc0}), 32'b010);
      ack = 1'b1; @(negedge clk); ack = 1'b0; @(negedge clk);
      settle(12);

      // Second edge on src0 while its request is outstanding.
      btn = 3'b001;
      wait_src("ovr_first", 3'b001);
      btn = 3'b000;
      repeat (10) @(negedge clk);
      btn = 3'b001;
      repeat (10) @(negedge clk);
`ifdef EXP_OVERRUN_CNT_EN
      check_val("ovr_cnt", 32'(overrun_cnt), 32'd1);
`endif
      check_val("ovr_pend", 32'(pending), 32'b001);
      check_val("ovr_src", 32'({expsrc2, expsrc1, expsrc0}), 32'b001);
      ack = 1'b1; @(negedge clk); ack = 1'b0;
      repeat (15) @(negedge clk);
      check_val("ovr_single", 32'({expsrc2, expsrc1, expsrc0}), 32'd0);
      check_val("ovr_clr", 32'(pending), 32'd0);
      settle(12);

      // Reset during REQ, button held across release.
      btn = 3'b100;
      wait_src("rst_req", 3'b100);
      #2 reset = 1'b1;
      #1;
      check_val("rreq_src", 32'({expsrc2, expsrc1, expsrc0}), 32'd0);
      check_val("rreq_pend", 32'(pending), 32'd0);
      check_val("rreq_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      check_val("held_early", 32'(pending), 32'd0);
      @(negedge clk);
      check_val("held_set", 32'(pending), 32'b100);
      serve("held_req", 2);
      repeat (10) @(negedge clk);
      check_val("held_once", 32'(pending), 32'd0);
      settle(12);

      // Randomized traffic against the model.
      hold_b = 0; hold_a = 0;
      for (int i = 0; i < 600; i++) begin
         if (hold_b == 0) begin
            btn    = 3'($urandom_range(0, 7));
            hold_b = $urandom_range(1, 12);
         end else begin
            hold_b--;
         end
         if (hold_a == 0) begin
            ack    = ($urandom_range(0, 2) == 0);
            hold_a = $urandom_range(1, 6);
         end else begin
            hold_a--;
         end
         expblock = ($urandom_range(0, 9) == 0);
         @(negedge clk);
      end
      settle(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/exp_request_gen.md
EXP_REQUEST_GEN -- requirements
Module: exp_request_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized samples required to accept a level change (range 2..65535).
REQ-002 Parameter CNT_W, default 16, debounce counter width; SHALL hold DEBOUNCE_CYCLES.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn  input  3  raw asynchronous exception buttons, bit n = source n.
REQ-006 expblock  input  1  CPU exception mask; high = no new grant.
REQ-007 ack  input  1  CPU level acknowledge (hasexp); high while exception taken.
REQ-008 expsrc0, expsrc1, expsrc2  output  1 each  one-hot exception request to CPU.
REQ-009 pending  output  3  latched, not-yet-serviced requests.
REQ-010 busy  output  1  high when FSM not IDLE.
REQ-011 overrun_cnt  output  8  present only with EXP_OVERRUN_CNT_EN.

Function
REQ-012 Each btn bit SHALL pass a 2-flop synchronizer before any other use.
REQ-013 Per bit: debounced level SHALL change only after DEBOUNCE_CYCLES consecutive synchronized samples differ from it; any matching sample restarts the count at 0.
REQ-014 A 0->1 transition of a debounced level SHALL set its pending bit the following cycle.
REQ-015 Latency: btn rise to pending set SHALL be exactly 2 + DEBOUNCE_CYCLES + 1 cycles for a clean edge.
REQ-016 FSM states IDLE, REQ, WAIT_DONE.
REQ-017 IDLE: if pending != 0 and expblock low, latch grant id (priority 2 > 1 > 0), go REQ; else stay.
REQ-018 REQ: assert only the granted expsrcN; hold until ack high; on ack high clear granted pending bit, drop expsrc, go WAIT_DONE.
REQ-019 WAIT_DONE: stay while ack high; on ack low go IDLE.
REQ-020 Grant id SHALL not change while in REQ even if higher-priority pending arrives or expblock rises.
REQ-021 Set and clear of the same pending bit in one cycle: set wins, bit stays 1.
REQ-022 Edge on a source whose pending bit is already 1 SHALL be absorbed (overrun); no second request.
REQ-023 expsrc outputs SHALL be registered and at most one high in any cycle.
REQ-024 ack high while in IDLE SHALL be ignored.

Reset
REQ-025 reset high SHALL immediately clear synchronizers, debounced levels, counters, pending, grant id, overrun_cnt; FSM to IDLE; all outputs 0.
REQ-026 Reset mid-REQ SHALL drop expsrc asynchronously; the request is lost.
REQ-027 A btn held high across reset release SHALL produce one request after the REQ-015 latency.

Configuration
REQ-028 With EXP_OVERRUN_CNT_EN defined: overrun_cnt increments by 1 per REQ-022 event, saturating at 255; simultaneous overruns on several sources add only 1.
REQ-029 Without EXP_OVERRUN_CNT_EN: port and counter absent; overruns silently absorbed.

Structure
REQ-030 Shared package exp_pkg: FSM state enum, NUM_EXP_SRC = 3, source id type, priority order constant.
REQ-031 One sub-module debounce_sync (synchronizer + counter + debounced level + rise pulse), instantiated 3 times.

Verification (DEBOUNCE_CYCLES = 4)
REQ-032 btn=3'b001 clean rise -> pending=3'b001 after 7 cycles; expsrc0=1 next cycle; ack pulse 3 cycles -> expsrc0=0, pending=0, busy=0 one cycle after ack low.
REQ-033 btn toggling every 2 cycles for 40 cycles -> pending stays 0, no expsrc.
REQ-034 btn=3'b111 simultaneous -> expsrc2 first; after ack cycle expsrc1, then expsrc0; never two high.
REQ-035 expblock=1 with pending=3'b010 -> no expsrc for 20 cycles; expblock=0 -> expsrc1 next cycle.
REQ-036 Second debounced edge on src0 while in REQ for src0 -> overrun_cnt=1, single request (macro defined).
REQ-037 reset asserted in REQ -> expsrc=0 and pending=0 same cycle, busy=0.
